// File: rtl/button_conditioner.sv
// Purpose: synchronise, debounce and edge-detect active-low push buttons, with hold detect and auto-repeat.
// Latency: a pin change seen from sampling edge k+1 reaches btn_level/btn_press at edge k+DEBOUNCE_CYCLES+2.
// Backpressure: none; every output is a registered level or a one-cycle pulse, and the consumer must take it.
module button_conditioner #(
    parameter int N_BTN           = 4,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLD_CYCLES     = 32,
    parameter int REPEAT_CYCLES   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_n,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_hold,
    output logic             any_press
);

    localparam int DW   = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int HMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int HW   = $clog2(HMAX + 1);

    localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] H_LAST = HW'(HOLD_CYCLES - 1);
    // With auto-repeat disabled this constant is never compared against.
    localparam logic [HW-1:0] R_LAST = (REPEAT_CYCLES > 0) ? HW'(REPEAT_CYCLES - 1) : '0;

    logic [N_BTN-1:0] sync1;
    logic [N_BTN-1:0] sync2;
    logic [N_BTN-1:0] s;

    logic [DW-1:0] dcnt     [N_BTN];
    logic [DW-1:0] dcnt_nxt [N_BTN];
    logic [HW-1:0] hcnt     [N_BTN];
    logic [HW-1:0] hcnt_nxt [N_BTN];

    logic [N_BTN-1:0] level_nxt;
    logic [N_BTN-1:0] press_nxt;
    logic [N_BTN-1:0] release_nxt;
    logic [N_BTN-1:0] hold_nxt;

    // Synchronised pin, flipped to active-high.
    assign s = ~sync2;

    // Per-channel next state: debounce first, then hold/repeat timing on the debounced level.
    always_comb begin
        for (int i = 0; i < N_BTN; i++) begin
            dcnt_nxt[i]    = dcnt[i];
            hcnt_nxt[i]    = hcnt[i];
            level_nxt[i]   = btn_level[i];
            press_nxt[i]   = 1'b0;
            release_nxt[i] = 1'b0;
            hold_nxt[i]    = btn_hold[i];

            // Debounce: a bounce back to the current level throws away all progress.
            if (s[i] == btn_level[i]) begin
                dcnt_nxt[i] = '0;
            end else if (dcnt[i] == D_LAST) begin
                dcnt_nxt[i]    = '0;
                level_nxt[i]   = s[i];
                press_nxt[i]   = s[i];
                release_nxt[i] = ~s[i];
            end else begin
                dcnt_nxt[i] = dcnt[i] + 1'b1;
            end

            // Hold/repeat: idle while released, restart on press, drop hold on the release edge.
            if (!btn_level[i] || !level_nxt[i]) begin
                hcnt_nxt[i] = '0;
                hold_nxt[i] = 1'b0;
            end else if (!btn_hold[i]) begin
                if (hcnt[i] == H_LAST) begin
                    hcnt_nxt[i] = '0;
                    hold_nxt[i] = 1'b1;
                end else begin
                    hcnt_nxt[i] = hcnt[i] + 1'b1;
                end
            end else if (REPEAT_CYCLES > 0) begin
                if (hcnt[i] == R_LAST) begin
                    hcnt_nxt[i]  = '0;
                    press_nxt[i] = 1'b1;
                end else begin
                    hcnt_nxt[i] = hcnt[i] + 1'b1;
                end
            end
            // Auto-repeat disabled: hcnt simply parks where it is.
        end
    end

    // Register synchronisers, counters and all outputs; reset looks like every button released.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1       <= '1;
            sync2       <= '1;
            btn_level   <= '0;
            btn_press   <= '0;
            btn_release <= '0;
            btn_hold    <= '0;
            any_press   <= 1'b0;
            for (int i = 0; i < N_BTN; i++) begin
                dcnt[i] <= '0;
                hcnt[i] <= '0;
            end
        end else begin
            sync1       <= btn_n;
            sync2       <= sync1;
            btn_level   <= level_nxt;
            btn_press   <= press_nxt;
            btn_release <= release_nxt;
            btn_hold    <= hold_nxt;
            any_press   <= |press_nxt;
            for (int i = 0; i < N_BTN; i++) begin
                dcnt[i] <= dcnt_nxt[i];
                hcnt[i] <= hcnt_nxt[i];
            end
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: default build plus a build with auto-repeat disabled.
// Inputs change 1 time unit after a rising edge; outputs are sampled 1 time unit after a rising edge.
// Table vectors cover debounce latency, glitch rejection, release and simultaneous presses.
module tb_button_conditioner;

    logic       clk;
    logic       reset;
    logic [3:0] btn_n;

    logic [3:0] btn_level, btn_press, btn_release, btn_hold;
    logic       any_press;
    logic [3:0] r0_level, r0_press, r0_release, r0_hold;
    logic       r0_any;

    int checks = 0;
    int errors = 0;

    button_conditioner dut (
        .clk         (clk),
        .reset       (reset),
        .btn_n       (btn_n),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_hold    (btn_hold),
        .any_press   (any_press)
    );

    button_conditioner #(.REPEAT_CYCLES(0)) dut_norep (
        .clk         (clk),
        .reset       (reset),
        .btn_n       (btn_n),
        .btn_level   (r0_level),
        .btn_press   (r0_press),
        .btn_release (r0_release),
        .btn_hold    (r0_hold),
        .any_press   (r0_any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] btn_n;
        int         adv;
        logic [3:0] lvl;
        logic [3:0] prs;
        logic [3:0] rel;
        logic [3:0] hld;
        logic       any;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int npress, pedge, nrel, exp_p, hold_rise, hold_fall, rel_edge;
        int d0_press, d0_rise, d0_fall, d0_rel;

        // Rows: pin pattern applied now, edges to advance, expected outputs after the last edge.
        vecs[0]  = '{4'b1110, 3, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0}; // 3-cycle glitch
        vecs[1]  = '{4'b1111, 4, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0}; // glitch rejected
        vecs[2]  = '{4'b1110, 5, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0}; // one edge short
        vecs[3]  = '{4'b1110, 1, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b1}; // press at +6
        vecs[4]  = '{4'b1110, 1, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0}; // single-cycle pulse
        vecs[5]  = '{4'b1111, 5, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0};
        vecs[6]  = '{4'b1111, 1, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 1'b0}; // release at +6
        vecs[7]  = '{4'b1111, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0};
        vecs[8]  = '{4'b0101, 5, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0};
        vecs[9]  = '{4'b0101, 1, 4'b1010, 4'b1010, 4'b0000, 4'b0000, 1'b1}; // simultaneous press
        vecs[10] = '{4'b0101, 1, 4'b1010, 4'b0000, 4'b0000, 4'b0000, 1'b0};
        vecs[11] = '{4'b1111, 5, 4'b1010, 4'b0000, 4'b0000, 4'b0000, 1'b0};
        vecs[12] = '{4'b1111, 1, 4'b0000, 4'b0000, 4'b1010, 4'b0000, 1'b0};
        vecs[13] = '{4'b1111, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0};

        // Reset state
        reset = 1'b1;
        btn_n = 4'b1111;
        #1;
        check("rst_level",   32'(btn_level),   32'h0);
        check("rst_press",   32'(btn_press),   32'h0);
        check("rst_release", 32'(btn_release), 32'h0);
        check("rst_hold",    32'(btn_hold),    32'h0);
        check("rst_any",     32'(any_press),   32'h0);
        check("rst_norep",   32'({r0_level, r0_press, r0_release, r0_hold, r0_any}), 32'h0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) tick();

        // Table-driven vectors
        for (int i = 0; i < 14; i++) begin
            btn_n = vecs[i].btn_n;
            repeat (vecs[i].adv) @(posedge clk);
            #1;
            check($sformatf("vec%0d_level", i),   32'(btn_level),   32'(vecs[i].lvl));
            check($sformatf("vec%0d_press", i),   32'(btn_press),   32'(vecs[i].prs));
            check($sformatf("vec%0d_release", i), 32'(btn_release), 32'(vecs[i].rel));
            check($sformatf("vec%0d_hold", i),    32'(btn_hold),    32'(vecs[i].hld));
            check($sformatf("vec%0d_any", i),     32'(any_press),   32'(vecs[i].any));
        end
        repeat (3) tick();

        // Bounce on button 1: 2-low/2-high for 20 cycles, then held low from edge 20
        npress = 0;
        pedge  = -1;
        for (int c = 1; c <= 32; c++) begin
            int k;
            k = c - 1;
            if (k < 20 && ((k / 2) % 2) == 1) btn_n = 4'b1111;
            else                              btn_n = 4'b1101;
            tick();
            if (btn_press != 4'b0000) begin
                npress++;
                pedge = c;
            end
        end
        check("bounce_press_count", 32'(npress), 32'd1);
        check("bounce_press_edge",  32'(pedge),  32'd26);
        btn_n = 4'b1111;
        repeat (10) tick();

        // Hold on button 2 for 100 cycles, then release
        npress = 0; nrel = 0; exp_p = 6;
        hold_rise = -1; hold_fall = -1; rel_edge = -1;
        d0_press = 0; d0_rise = -1; d0_fall = -1; d0_rel = -1;
        for (int c = 1; c <= 112; c++) begin
            btn_n = (c - 1 < 100) ? 4'b1011 : 4'b1111;
            tick();
            if (btn_press[2]) begin
                check("hold_press_edge", 32'(c), 32'(exp_p));
                exp_p = (npress == 0) ? 46 : exp_p + 8;
                npress++;
            end
            if (btn_hold[2] && hold_rise < 0) hold_rise = c;
            if (!btn_hold[2] && hold_rise >= 0 && hold_fall < 0) hold_fall = c;
            if (btn_release[2]) begin
                nrel++;
                rel_edge = c;
            end
            if (r0_press[2]) d0_press++;
            if (r0_hold[2] && d0_rise < 0) d0_rise = c;
            if (!r0_hold[2] && d0_rise >= 0 && d0_fall < 0) d0_fall = c;
            if (r0_release[2]) d0_rel = c;
        end
        check("hold_press_count",  32'(npress),    32'd9);
        check("hold_rise_edge",    32'(hold_rise), 32'd38);
        check("hold_fall_edge",    32'(hold_fall), 32'd106);
        check("hold_release_edge", 32'(rel_edge),  32'd106);
        check("hold_release_cnt",  32'(nrel),      32'd1);
        check("norep_press_count", 32'(d0_press),  32'd1);
        check("norep_hold_rise",   32'(d0_rise),   32'd38);
        check("norep_hold_fall",   32'(d0_fall),   32'd106);
        check("norep_release",     32'(d0_rel),    32'd106);
        repeat (3) tick();

        // Async reset while button 3 is held
        btn_n = 4'b0111;
        repeat (10) tick();
        check("pre_reset_level", 32'(btn_level), 32'h8);
        #3;
        reset = 1'b1;
        #1;
        check("async_rst_level", 32'(btn_level), 32'h0);
        check("async_rst_outs",  32'({btn_press, btn_release, btn_hold, any_press}), 32'h0);
        check("async_rst_norep", 32'(r0_level),  32'h0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        npress = 0; pedge = -1; nrel = 0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (btn_press[3]) begin
                npress++;
                pedge = c;
            end
            if (btn_release != 4'b0000) nrel++;
        end
        check("rerst_press_count", 32'(npress),    32'd1);
        check("rerst_press_edge",  32'(pedge),     32'd6);
        check("rerst_no_release",  32'(nrel),      32'd0);
        check("rerst_level",       32'(btn_level), 32'h8);
        check("rerst_norep_level", 32'(r0_level),  32'h8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
